mips_cpu_bus_arbiter: RTL
=========================

# mips_cpu_bus_arbiter

Two-port arbiter that shares the CPU's single Avalon-style memory port (the 32-bit RAM with `waitrequest`, `byteenable` and one-cycle registered `readdata`) between the instruction-fetch port and the load/store data port. It sits between the CPU core and the memory model. It holds each grant for one complete transaction and returns read data to the port that issued the read, with a valid strobe.

## Interface
- No parameters.
- `clk` in 1: system clock, rising-edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `i_address` in 32: instruction-fetch byte address.
- `i_read` in 1: instruction-fetch read request.
- `i_waitrequest` out 1: high while the fetch request is not yet accepted.
- `i_readdata` out 32: fetch read data, meaningful only when `i_readvalid` is high.
- `i_readvalid` out 1: one-cycle strobe that marks fetch read data as valid.
- `d_address` in 32: data-port byte address.
- `d_read` in 1: data read request.
- `d_write` in 1: data write request.
- `d_writedata` in 32: data write value.
- `d_byteenable` in 4: byte lanes for the data access.
- `d_waitrequest` out 1: high while the data request is not yet accepted.
- `d_readdata` out 32: data-port read data.
- `d_readvalid` out 1: one-cycle strobe that marks data-port read data as valid.
- `m_address` out 32: address to memory.
- `m_read` out 1: read strobe to memory.
- `m_write` out 1: write strobe to memory.
- `m_writedata` out 32: write data to memory.
- `m_byteenable` out 4: byte lanes to memory.
- `m_waitrequest` in 1: memory stall.
- `m_readdata` in 32: memory read data, valid on the cycle after read acceptance.

## Operation
- FSM states:
  - IDLE: no transaction in progress.
  - GRANT_I: memory port driven from the fetch port.
  - GRANT_D: memory port driven from the data port.
  - RESP_I / RESP_D: one cycle in which memory read data returns to the issuing port.
- IDLE transitions:
  - Only the fetch port requests → GRANT_I.
  - Only the data port requests → GRANT_D.
  - Both request → arbitration decides (see Configuration).
  - No request → stay in IDLE.
- GRANT_x behaviour:
  - `m_*` is a combinational copy of port x's request signals.
  - `x_waitrequest` = `m_waitrequest`. The other port's waitrequest is held at 1.
- Acceptance: the transaction is accepted at the rising edge where the state is GRANT_x and `m_waitrequest`=0.
  - Read accepted → RESP_x.
  - Write accepted → IDLE.
- GRANT_x with the request dropped (protocol violation): return to IDLE on the next edge with no memory access.
- RESP_x:
  - `x_readvalid`=1.
  - `x_readdata` = `m_readdata`.
  - Next state is IDLE.
- Read and write signals:
  - `d_read` and `d_write` both high → treated as a write; `m_read`=0.
  - The fetch port never writes: in GRANT_I, `m_write`=0 and `m_byteenable`=4'hF.
- Outside GRANT states:
  - `m_read`=`m_write`=0.
  - `m_address`, `m_writedata` and `m_byteenable` are 0.
  - Both waitrequests are 1.
- Readdata outside RESP_x: `i_readdata` and `d_readdata` are 0 whenever their `readvalid` is 0.
- Address 0 (halt address): passed through unchanged; the arbiter does not special-case it.

## Timing
- Reset values (asynchronous, immediate when `reset_n`=0):
  - State IDLE.
  - `m_read`, `m_write`, `m_address`, `m_writedata`, `m_byteenable` all 0.
  - `i_waitrequest`=`d_waitrequest`=1.
  - Both readvalids 0, both readdatas 0.
  - Round-robin pointer points at the fetch port (fetch wins the first tie).
- Reset mid-transaction aborts it: no readvalid is issued afterwards, and the requester must re-issue.
- Read latency with zero memory stall:
  - Request seen in IDLE at cycle 0.
  - Grant at cycle 1, accepted at the end of cycle 1.
  - `readvalid` in cycle 2.
- Write latency: accepted at the end of cycle 1.
- Each memory stall cycle adds one cycle.
- Maximum throughput: one read every 3 cycles, one write every 2 cycles.
- A request arriving during GRANT or RESP waits; it is sampled only in IDLE.

## Configuration
- `ARB_ROUND_ROBIN_EN` defined:
  - Round-robin arbitration on ties.
  - A 1-bit `last_grant` register is updated on every transition into a GRANT state.
  - On a tie, the port not granted last wins.
- `ARB_ROUND_ROBIN_EN` undefined:
  - Fixed priority: the data port always wins ties.
  - No pointer register is present.

## Test plan
- Fetch read, `i_address`=32'hBFC00000, memory word 32'h24020005, no stall → `i_waitrequest` low in cycle 1; `i_readvalid`=1 with `i_readdata`=32'h24020005 in cycle 2; `d_readvalid` stays 0.
- Data write, `d_address`=32'hBFC00010, `d_writedata`=32'hDEADBEEF, `d_byteenable`=4'b0011 → `m_write`=1 for exactly one accepted cycle with those values; FSM back in IDLE the next cycle.
- Memory holds `m_waitrequest`=1 for 3 cycles during a data read → `d_waitrequest` mirrors it; `d_readvalid` appears exactly 1 cycle after `m_waitrequest` falls.
- Both ports request reads continuously for 4 transactions:
  - With `ARB_ROUND_ROBIN_EN`: grants go I,D,I,D.
  - Without `ARB_ROUND_ROBIN_EN`: grants go D,D,D,D while `d_read` is held, and the fetch port starves.
- `reset_n` pulsed low while in RESP_D → `d_readvalid` drops to 0 immediately; all `m_*` outputs are 0; both waitrequests are 1.
- `d_read`=`d_write`=1 at address 32'hBFC00004 → `m_write`=1, `m_read`=0, and no `d_readvalid` follows.

Source files
------------

// File: rtl/mips_cpu_bus_arbiter.sv
// Two-port arbiter sharing one Avalon-style memory port between instruction fetch and load/store.
// Define ARB_ROUND_ROBIN_EN for round-robin tie-breaking; otherwise the data port wins ties.
module mips_cpu_bus_arbiter (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] i_address,
  input  logic        i_read,
  output logic        i_waitrequest,
  output logic [31:0] i_readdata,
  output logic        i_readvalid,
  input  logic [31:0] d_address,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [31:0] d_writedata,
  input  logic [3:0]  d_byteenable,
  output logic        d_waitrequest,
  output logic [31:0] d_readdata,
  output logic        d_readvalid,
  output logic [31:0] m_address,
  output logic        m_read,
  output logic        m_write,
  output logic [31:0] m_writedata,
  output logic [3:0]  m_byteenable,
  input  logic        m_waitrequest,
  input  logic [31:0] m_readdata
);

  typedef enum logic [2:0] {IDLE, GRANT_I, GRANT_D, RESP_I, RESP_D} state_t;

  state_t state, next_state;
  logic   i_req, d_req, tie_to_d;

  assign i_req = i_read;
  assign d_req = d_read | d_write;

`ifdef ARB_ROUND_ROBIN_EN
  // last_grant = 1 means the data port was granted most recently, so fetch wins the next tie
  logic last_grant;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      last_grant <= 1'b1;
    else if (state == IDLE && next_state == GRANT_I)
      last_grant <= 1'b0;
    else if (state == IDLE && next_state == GRANT_D)
      last_grant <= 1'b1;
  end

  assign tie_to_d = ~last_grant;
`else
  assign tie_to_d = 1'b1;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      state <= IDLE;
    else
      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (i_req && d_req)
          next_state = tie_to_d ? GRANT_D : GRANT_I;
        else if (i_req)
          next_state = GRANT_I;
        else if (d_req)
          next_state = GRANT_D;
      end
      GRANT_I: begin
        if (!i_req)
          next_state = IDLE;
        else if (!m_waitrequest)
          next_state = RESP_I;
      end
      // A simultaneous read+write is a write, so it never produces a response cycle
      GRANT_D: begin
        if (!d_req)
          next_state = IDLE;
        else if (!m_waitrequest)
          next_state = d_write ? IDLE : RESP_D;
      end
      RESP_I:  next_state = IDLE;
      RESP_D:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    m_address     = 32'h0;
    m_read        = 1'b0;
    m_write       = 1'b0;
    m_writedata   = 32'h0;
    m_byteenable  = 4'h0;
    i_waitrequest = 1'b1;
    d_waitrequest = 1'b1;
    i_readvalid   = 1'b0;
    i_readdata    = 32'h0;
    d_readvalid   = 1'b0;
    d_readdata    = 32'h0;
    case (state)
      GRANT_I: begin
        m_address     = i_address;
        m_read        = i_read;
        m_byteenable  = 4'hF;
        i_waitrequest = m_waitrequest;
      end
      GRANT_D: begin
        m_address     = d_address;
        m_read        = d_read & ~d_write;
        m_write       = d_write;
        m_writedata   = d_writedata;
        m_byteenable  = d_byteenable;
        d_waitrequest = m_waitrequest;
      end
      RESP_I: begin
        i_readvalid = 1'b1;
        i_readdata  = m_readdata;
      end
      RESP_D: begin
        d_readvalid = 1'b1;
        d_readdata  = m_readdata;
      end
      default: ;
    endcase
  end

endmodule
